sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
//
// PURPOSE
// - Shares the single toggle-handshake SDRAM port (req/ack/we/a/ds/d/q) among three clients:
//   C0 = ROM/cart download loader, C1 = TMS9900 CPU bus, C2 = VDP/GROM fetch.
// - Each client sees its own toggle-handshake port; the arbiter serializes accesses, forwards one
//   latched request to the SDRAM controller and routes ack/read data back to the owner.
// - Sits between the system bus glue and the SDRAM controller; the SDRAM controller is unchanged.
//
// PARAMETERS
// - AW  24  word-address width (client and memory address bits [AW:1])
// - DW  16  data width
//
// PORTS
// - clk            in   1      system/SDRAM clock, same domain as the SDRAM controller
// - reset          in   1      asynchronous, active-high reset
// - cN_req         in   1      client N (N=0..2) request toggle; pending while cN_req != cN_ack
// - cN_ack         out  1      client N ack toggle; set equal to the cN_req value captured at grant
// - cN_we          in   1      client N write (1) / read (0)
// - cN_a           in   AW     client N word address [AW:1]
// - cN_ds          in   2      client N byte enables {hi,lo}
// - cN_d           in   DW     client N write data
// - cN_q           out  DW     client N read data, valid from the cycle cN_ack toggles
// - mem_req        out  1      toggle request to SDRAM controller
// - mem_ack        in   1      toggle ack from SDRAM controller (driven to equal mem_req when done)
// - mem_we/mem_a/mem_ds/mem_d  out  1/AW/2/DW  latched request fields to SDRAM controller
// - mem_q          in   DW     read data from SDRAM controller
// - gnt            out  3      one-hot owner of current access; 0 when idle
//
// BEHAVIOUR
// - Reset: state=IDLE; mem_req=0, mem_we=0, mem_a=0, mem_ds=0, mem_d=0; all cN_ack=0, cN_q=0;
//   gnt=0; rr pointer=C2 (so C0 is checked first).
// - pendN = cN_req ^ cN_ack. Clients must not toggle cN_req again until cN_ack matches it.
// - States: IDLE -> WAIT -> IDLE.
//   IDLE: grant only when mem_req == mem_ack (memory idle) and any pendN. On grant (1 cycle):
//     latch cN_we/a/ds/d into mem_*, latch reqval=cN_req, set gnt, mem_req <= ~mem_req, go WAIT.
//   WAIT: hold mem_* and gnt stable. When mem_ack == mem_req: if latched we=0, cN_q <= mem_q;
//     cN_ack <= reqval; gnt <= 0; go IDLE. Writes leave cN_q unchanged.
// - Latency: pendN seen in IDLE -> mem_req toggles next edge; ack-match -> cN_ack toggles next edge.
//   Back-to-back: next grant may occur in the cycle after returning to IDLE (1 idle cycle min).
// - Selection (default, fixed priority): C0 > C1 > C2.
// - Simultaneous events: new requests arriving while in WAIT stay pending; never lost, never
//   pre-empt. A client's inputs changing during WAIT have no effect (fields already latched).
// - Reset mid-operation: arbiter returns to IDLE with mem_req=0. If mem_ack != 0 after reset
//   (controller not reset together), IDLE stalls until mem_ack == mem_req; no spurious grant.
// - No timeout: a controller that never acks stalls the arbiter (controller guarantees ack).
//
// CONFIGURATION
// - SDRAM_ARB_RR_EN defined: round-robin. Search order starts at the client after the last
//   granted (rr pointer updated on every grant), wrapping C2 -> C0.
// - SDRAM_ARB_RR_EN undefined: fixed priority C0 > C1 > C2; rr pointer logic absent.
//
// TESTING
// - Single read: C1 reads a=0x000100 (we=0, ds=11), model returns 0xBEEF after 5 cycles ->
//   mem_req toggles once, gnt=010, c1_q=0xBEEF, c1_ack==c1_req, c0/c2 ack unchanged.
// - Write: C0 writes a=0x7FFFFF ds=10 d=0x12AB -> mem_we=1, mem_a=0x7FFFFF, mem_ds=10,
//   mem_d=0x12AB; c0_q stays 0; c0_ack toggles after mem_ack match.
// - Contention: C0,C1,C2 toggle req same cycle -> fixed mode grants C0,C1,C2 in order; with
//   SDRAM_ARB_RR_EN and C0 re-requesting each time, grants C0,C1,C2,C0 (C2 not starved).
// - Request during WAIT: C2 toggles while C1 in WAIT -> C2 granted one cycle after C1 ack, C1
//   read data 0x5555 not overwritten by C2 data 0xAAAA (each cN_q holds own value).
// - Reset mid-access: assert reset during WAIT with model holding mem_ack=1 -> all outputs 0,
//   no grant while mem_ack!=mem_req; after forcing mem_ack=0, pending C1 granted normally.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Serialises three toggle-handshake clients (loader, CPU, VDP/GROM) onto one SDRAM controller port.
// Fixed priority C0 > C1 > C2 by default; define SDRAM_ARB_RR_EN for round-robin selection.
module sdram_port_arbiter #(
  parameter int AW = 24,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c0_req,
  output logic          c0_ack,
  input  logic          c0_we,
  input  logic [AW:1]   c0_a,
  input  logic [1:0]    c0_ds,
  input  logic [DW-1:0] c0_d,
  output logic [DW-1:0] c0_q,
  input  logic          c1_req,
  output logic          c1_ack,
  input  logic          c1_we,
  input  logic [AW:1]   c1_a,
  input  logic [1:0]    c1_ds,
  input  logic [DW-1:0] c1_d,
  output logic [DW-1:0] c1_q,
  input  logic          c2_req,
  output logic          c2_ack,
  input  logic          c2_we,
  input  logic [AW:1]   c2_a,
  input  logic [1:0]    c2_ds,
  input  logic [DW-1:0] c2_d,
  output logic [DW-1:0] c2_q,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          mem_we,
  output logic [AW:1]   mem_a,
  output logic [1:0]    mem_ds,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q,
  output logic [2:0]    gnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [2:0]    req_v, we_v, pend, ack_r;
  logic [AW:1]   a_v  [3];
  logic [1:0]    ds_v [3];
  logic [DW-1:0] d_v  [3];
  logic [DW-1:0] q_r  [3];
  logic [1:0]    sel, owner, start;
  logic          reqval;

  // First pending client found walking upward from s, wrapping 2 -> 0.
  function automatic logic [1:0] first_pending(input logic [2:0] p, input logic [1:0] s);
    logic [1:0] c;
    logic [1:0] res;
    logic       found;
    c     = s;
    res   = s;
    found = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!found && p[c]) begin
        found = 1'b1;
        res   = c;
      end
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
    end
    return res;
  endfunction

  always_comb begin
    req_v   = {c2_req, c1_req, c0_req};
    we_v    = {c2_we, c1_we, c0_we};
    a_v[0]  = c0_a;
    a_v[1]  = c1_a;
    a_v[2]  = c2_a;
    ds_v[0] = c0_ds;
    ds_v[1] = c1_ds;
    ds_v[2] = c2_ds;
    d_v[0]  = c0_d;
    d_v[1]  = c1_d;
    d_v[2]  = c2_d;
  end

  assign pend = req_v ^ ack_r;

`ifdef SDRAM_ARB_RR_EN
  logic [1:0] rr;
  assign start = (rr == 2'd2) ? 2'd0 : rr + 2'd1;
`else
  assign start = 2'd0;
`endif

  assign sel = first_pending(pend, start);

  assign c0_ack = ack_r[0];
  assign c1_ack = ack_r[1];
  assign c2_ack = ack_r[2];
  assign c0_q   = q_r[0];
  assign c1_q   = q_r[1];
  assign c2_q   = q_r[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      mem_a   <= '0;
      mem_ds  <= '0;
      mem_d   <= '0;
      ack_r   <= '0;
      q_r[0]  <= '0;
      q_r[1]  <= '0;
      q_r[2]  <= '0;
      gnt     <= '0;
      owner   <= '0;
      reqval  <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      rr      <= 2'd2;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Memory must be idle too: after a lone arbiter reset the controller may still owe an ack.
          if ((mem_req == mem_ack) && (|pend)) begin
            mem_we  <= we_v[sel];
            mem_a   <= a_v[sel];
            mem_ds  <= ds_v[sel];
            mem_d   <= d_v[sel];
            reqval  <= req_v[sel];
            owner   <= sel;
            gnt     <= 3'b001 << sel;
            mem_req <= ~mem_req;
            state   <= WAIT;
`ifdef SDRAM_ARB_RR_EN
            rr      <= sel;
`endif
          end
        end
        WAIT: begin
          if (mem_ack == mem_req) begin
            if (!mem_we) q_r[owner] <= mem_q;
            ack_r[owner] <= reqval;
            gnt          <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level reference (grant order + byte-merged memory).
module tb_sdram_port_arbiter;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req   = '0;
  logic [2:0]  we    = '0;
  logic [23:0] a  [3];
  logic [1:0]  ds [3];
  logic [15:0] d  [3];
  wire  [2:0]  ack;
  wire  [15:0] q0, q1, q2;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_q   = '0;
  wire         mem_req, mem_we;
  wire  [23:0] mem_a;
  wire  [1:0]  mem_ds;
  wire  [15:0] mem_d;
  wire  [2:0]  gnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] cmem [logic [23:0]];
  logic [15:0] rmem [logic [23:0]];
  bit ctl_en = 1'b1, ctl_rand = 1'b0, hold_ack = 1'b0;

  typedef struct {
    int          c;
    bit          w;
    logic [23:0] ad;
    logic [1:0]  bs;
    logic [15:0] dd;
    logic [15:0] exp_q;
  } vec_t;
  vec_t tbl [8];

  bit [2:0]    outst;
  int          owner, last, exp_c;
  bit          exp_grant;
  bit          rw  [3];
  logic [23:0] ra  [3];
  logic [1:0]  rds [3];
  logic [15:0] rdd [3];
  int          gq [$];
  int          exp_order [$];
  logic [2:0]  prevg;
  int          reiss;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.AW(24), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .c0_req(req[0]), .c0_ack(ack[0]), .c0_we(we[0]), .c0_a(a[0]), .c0_ds(ds[0]), .c0_d(d[0]), .c0_q(q0),
    .c1_req(req[1]), .c1_ack(ack[1]), .c1_we(we[1]), .c1_a(a[1]), .c1_ds(ds[1]), .c1_d(d[1]), .c1_q(q1),
    .c2_req(req[2]), .c2_ack(ack[2]), .c2_we(we[2]), .c2_a(a[2]), .c2_ds(ds[2]), .c2_d(d[2]), .c2_q(q2),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_a(mem_a), .mem_ds(mem_ds),
    .mem_d(mem_d), .mem_q(mem_q), .gnt(gnt)
  );

  function automatic logic [15:0] init_val(input logic [23:0] x);
    return x[15:0] ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nd, input logic [1:0] be);
    return {be[1] ? nd[15:8] : old[15:8], be[0] ? nd[7:0] : old[7:0]};
  endfunction

  function automatic logic [15:0] crd(input logic [23:0] x);
    return cmem.exists(x) ? cmem[x] : init_val(x);
  endfunction

  function automatic logic [15:0] rrd(input logic [23:0] x);
    return rmem.exists(x) ? rmem[x] : init_val(x);
  endfunction

  function automatic logic [15:0] q_of(input int c);
    return (c == 0) ? q0 : ((c == 1) ? q1 : q2);
  endfunction

  function automatic logic [2:0] onehot(input int c);
    return 3'(1 << c);
  endfunction

  function automatic int pick(input bit [2:0] p, input int lst);
`ifdef SDRAM_ARB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      int i = (lst + k) % 3;
      if (p[i]) return i;
    end
`else
    for (int i = 0; i < 3; i++) if (p[i]) return i;
`endif
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // SDRAM controller model: services a toggled request after a fixed or random latency.
  initial begin : ctl
    bit busy;
    int cnt;
    busy = 1'b0;
    cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!ctl_en) begin
        busy    = 1'b0;
        mem_ack = hold_ack;
      end else if (reset) begin
        busy    = 1'b0;
        mem_ack = 1'b0;
      end else if (!busy) begin
        if (mem_req !== mem_ack) begin
          busy = 1'b1;
          cnt  = ctl_rand ? int'($urandom_range(6, 1)) : 5;
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          if (mem_we) cmem[mem_a] = merge(crd(mem_a), mem_d, mem_ds);
          else        mem_q = crd(mem_a);
          mem_ack = mem_req;
          busy    = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_ack(input int c, input string nm);
    int n;
    n = 0;
    while (ack[c] !== req[c] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ack"}, 32'(ack[c]), 32'(req[c]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_fields", 32'({mem_we, mem_ds} ^ mem_a ^ 24'(mem_d)), 32'd0);
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset q", 32'(q0 | q1 | q2), 32'd0);
    chk("reset gnt", 32'(gnt), 32'd0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_txn(input int c, input bit w, input logic [23:0] ad, input logic [1:0] bs,
                        input logic [15:0] dd, input logic [15:0] exp_q, input string nm);
    logic [2:0] ack0, m;
    logic       exp_mr;
    ack0   = ack;
    exp_mr = ~mem_req;
    m      = ~onehot(c);
    we[c] = w; a[c] = ad; ds[c] = bs; d[c] = dd;
    req[c] = ~req[c];
    @(negedge clk);
    chk({nm, " mem_req"}, 32'(mem_req), 32'(exp_mr));
    chk({nm, " gnt"}, 32'(gnt), 32'(onehot(c)));
    chk({nm, " mem_we"}, 32'(mem_we), 32'(w));
    chk({nm, " mem_a"}, 32'(mem_a), 32'(ad));
    chk({nm, " mem_ds"}, 32'(mem_ds), 32'(bs));
    if (w) chk({nm, " mem_d"}, 32'(mem_d), 32'(dd));
    a[c] = 24'($urandom); d[c] = 16'($urandom); ds[c] = 2'($urandom); we[c] = ~w;
    wait_ack(c, nm);
    chk({nm, " q"}, 32'(q_of(c)), 32'(exp_q));
    chk({nm, " other acks"}, 32'(ack & m), 32'(ack0 & m));
    chk({nm, " gnt idle"}, 32'(gnt), 32'd0);
    chk({nm, " single toggle"}, 32'(mem_req), 32'(exp_mr));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      a[i] = '0; ds[i] = '0; d[i] = '0;
    end
    cmem[24'h000100] = 16'hBEEF;
    cmem[24'h7FFFFF] = 16'h0000;
    cmem[24'h000200] = 16'h5A5A;
    cmem[24'h000300] = 16'h5555;
    cmem[24'h000400] = 16'hAAAA;
    exp_order = '{0, 1, 2};
`ifdef SDRAM_ARB_RR_EN
    exp_order.push_back(0);
`endif

    do_reset();

    tbl[0] = '{1, 1'b0, 24'h000100, 2'b11, 16'h0000, 16'hBEEF};
    tbl[1] = '{0, 1'b1, 24'h7FFFFF, 2'b10, 16'h12AB, 16'h0000};
    tbl[2] = '{0, 1'b0, 24'h7FFFFF, 2'b11, 16'h0000, 16'h1200};
    tbl[3] = '{2, 1'b0, 24'h000200, 2'b11, 16'h0000, 16'h5A5A};
    tbl[4] = '{2, 1'b1, 24'h000200, 2'b01, 16'hFF33, 16'h5A5A};
    tbl[5] = '{2, 1'b0, 24'h000200, 2'b11, 16'h0000, 16'h5A33};
    tbl[6] = '{1, 1'b1, 24'h000100, 2'b11, 16'h0F0F, 16'hBEEF};
    tbl[7] = '{1, 1'b0, 24'h000100, 2'b11, 16'h0000, 16'h0F0F};
    for (int i = 0; i < 8; i++)
      do_txn(tbl[i].c, tbl[i].w, tbl[i].ad, tbl[i].bs, tbl[i].dd, tbl[i].exp_q, $sformatf("vec%0d", i));

    // C2 arrives while C1 is in flight
    we[1] = 1'b0; a[1] = 24'h000300; ds[1] = 2'b11; req[1] = ~req[1];
    @(negedge clk);
    chk("wait c1 gnt", 32'(gnt), 32'(3'b010));
    we[2] = 1'b0; a[2] = 24'h000400; ds[2] = 2'b11; req[2] = ~req[2];
    wait_ack(1, "wait c1");
    chk("wait gap gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("wait c2 gnt", 32'(gnt), 32'(3'b100));
    wait_ack(2, "wait c2");
    chk("wait c1 q", 32'(q1), 32'(16'h5555));
    chk("wait c2 q", 32'(q2), 32'(16'hAAAA));
    @(negedge clk);

    // all three clients toggle in the same cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      we[i] = 1'b0; a[i] = 24'h000010 + 24'(i); ds[i] = 2'b11;
    end
    req   = ~req;
    prevg = 3'b000;
    reiss = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (prevg == 3'b000 && gnt != 3'b000) gq.push_back(gnt == 3'b001 ? 0 : (gnt == 3'b010 ? 1 : 2));
      prevg = gnt;
`ifdef SDRAM_ARB_RR_EN
      if (reiss == 0 && ack[0] === req[0]) begin
        req[0] = ~req[0];
        reiss  = 1;
      end
`endif
      if (ack === req && gq.size() == exp_order.size()) break;
    end
    chk("contend count", 32'(gq.size()), 32'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < gq.size(); i++)
      chk($sformatf("contend grant%0d", i), 32'(gq[i]), 32'(exp_order[i]));
    chk("contend q0", 32'(q0), 32'(init_val(24'h000010)));
    chk("contend q2", 32'(q2), 32'(init_val(24'h000012)));
    @(negedge clk);

    // reset during WAIT while the controller still owes an ack
    do_reset();
    ctl_en = 1'b0;
    hold_ack = 1'b0;
    we[1] = 1'b0; a[1] = 24'h000300; ds[1] = 2'b11; req[1] = ~req[1];
    @(negedge clk);
    chk("midrst gnt", 32'(gnt), 32'(3'b010));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    hold_ack = 1'b1;
    #1;
    chk("midrst async mem_req", 32'(mem_req), 32'd0);
    chk("midrst async gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("midrst ack", 32'(ack), 32'd0);
    chk("midrst q1", 32'(q1), 32'd0);
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("midrst stall gnt", 32'(gnt), 32'd0);
      chk("midrst stall mem_req", 32'(mem_req), 32'd0);
    end
    hold_ack = 1'b0;
    @(negedge clk);
    chk("midrst still idle", 32'(gnt), 32'd0);
    ctl_en = 1'b1;
    @(negedge clk);
    chk("midrst regrant", 32'(gnt), 32'(3'b010));
    wait_ack(1, "midrst c1");
    chk("midrst c1 q", 32'(q1), 32'(16'h5555));
    @(negedge clk);

    // randomized traffic against the transaction-level reference
    do_reset();
    ctl_rand  = 1'b1;
    outst     = '0;
    owner     = -1;
    last      = 2;
    exp_grant = 1'b0;
    exp_c     = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (exp_grant) begin
        chk("rnd grant", 32'(gnt), 32'(onehot(exp_c)));
        chk("rnd mem_a", 32'(mem_a), 32'(ra[exp_c]));
        chk("rnd mem_we", 32'(mem_we), 32'(rw[exp_c]));
        chk("rnd mem_ds", 32'(mem_ds), 32'(rds[exp_c]));
        if (rw[exp_c]) chk("rnd mem_d", 32'(mem_d), 32'(rdd[exp_c]));
        owner = exp_c;
        last  = exp_c;
        a[exp_c] = 24'($urandom); d[exp_c] = 16'($urandom); ds[exp_c] = 2'($urandom);
        we[exp_c] = ~we[exp_c];
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (outst[i] && ack[i] === req[i]) begin
            chk("rnd ack owner", 32'(i), 32'(owner));
            if (rw[i]) rmem[ra[i]] = merge(rrd(ra[i]), rdd[i], rds[i]);
            else       chk("rnd read data", 32'(q_of(i)), 32'(rrd(ra[i])));
            outst[i] = 1'b0;
            if (i == owner) owner = -1;
          end
        end
        chk("rnd gnt", 32'(gnt), 32'(owner >= 0 ? onehot(owner) : 3'b000));
      end
      if (cyc < 2800) begin
        for (int i = 0; i < 3; i++) begin
          if (!outst[i] && $urandom_range(2, 0) == 0) begin
            rw[i]  = ($urandom_range(1, 0) == 1);
            ra[i]  = 24'hA00000 | 24'($urandom_range(7, 0));
            rds[i] = 2'($urandom);
            rdd[i] = 16'($urandom);
            we[i] = rw[i]; a[i] = ra[i]; ds[i] = rds[i]; d[i] = rdd[i];
            req[i]   = ~req[i];
            outst[i] = 1'b1;
          end
        end
      end
      exp_grant = (owner < 0) && (outst != 3'b000);
      if (exp_grant) exp_c = pick(outst, last);
    end
    chk("rnd drained", 32'(outst), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
